approx_mult_ctrl: RTL and testbench

- FSM controller that sequences the approximate-multiplier datapath.
- Reads 8 operand pairs from the 16-entry input RAM:
  - Normalises each operand by left-shifting until its MSB is 1, counting the shifts.
  - Multiplies the top 8 bits of the two normalised operands.
  - Right-shifts the 32-bit product by the total shift count.
  - Writes the result to the 8-entry output RAM.
- Sits beside the datapath. Drives every load, increment, counter-reset, shift and write strobe, and consumes the datapath's MSB and carry status.
- Exposes a start/busy/done handshake to the top level.

---
 rtl/approx_mult_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_approx_mult_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_ctrl.sv
// ---------------------------------------------------------------------------
// approx_mult_ctrl
//
// Sequencing FSM for the approximate-multiplier datapath. One batch reads
// 8 operand pairs from the 16-entry input RAM. For each pair it:
//   - normalises both operands,
//   - multiplies their top bytes,
//   - right-shifts the product back by both shift counts,
//   - writes the result to the 8-entry output RAM.
//
// The controller issues the datapath strobes and reads back the datapath's
// MSB and carry status.
//
// Optional feature (macro APPROX_MULT_CTRL_PERF_EN):
//   Adds a saturating busy-cycle counter on output `cycles`.
//
// Parameters:
//   RD_WAIT  wait cycles after an input-RAM address change (legal 1..3)
//   PERF_W   width of the optional cycle counter
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin a batch (sampled in IDLE only)
//   MSB_reg_out1/2            bit 15 of the operand-A / operand-B shift regs
//   carry2/carry3/carry4      counter 2 / 3 / 4 equal to 7
//   ld1, ld2                  load operand-A / operand-B shift register
//   ld3, ld5                  load counter 3 / counter 2 with 7 - count
//   ld4                       load product register
//   Inc1..Inc4                increment counters 1..4
//   Countrst1..Countrst4      synchronous clear of counters 1..4
//   Shle1, Shle2              left-shift operand A / B
//   Shre                      right-shift product
//   We                        output RAM write enable
//   busy                      high in every state but IDLE
//   done                      one-cycle pulse at batch end
//   cycles (optional)         busy-cycle counter
// ---------------------------------------------------------------------------
module approx_mult_ctrl #(
    parameter int RD_WAIT = 1,
    parameter int PERF_W  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic MSB_reg_out1,
    input  logic MSB_reg_out2,
    input  logic carry2,
    input  logic carry3,
    input  logic carry4,
    output logic ld1,
    output logic ld2,
    output logic ld3,
    output logic ld4,
    output logic ld5,
    output logic Inc1,
    output logic Inc2,
    output logic Inc3,
    output logic Inc4,
    output logic Countrst1,
    output logic Countrst2,
    output logic Countrst3,
    output logic Countrst4,
    output logic Shle1,
    output logic Shle2,
    output logic Shre,
    output logic We,
    output logic busy,
    output logic done
`ifdef APPROX_MULT_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] cycles
`endif
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        INIT    = 4'd1,
        FETCH_A = 4'd2,
        LOAD_A  = 4'd3,
        FETCH_B = 4'd4,
        LOAD_B  = 4'd5,
        NORM    = 4'd6,
        MULT    = 4'd7,
        SHR_A   = 4'd8,
        SHR_B   = 4'd9,
        WRITE   = 4'd10,
        NEXT    = 4'd11,
        DONE    = 4'd12
    } state_t;

    state_t     state_r;
    state_t     state_nx_s;
    logic [1:0] wait_cnt_r;
    logic       wait_last_s;
    logic       fetching_s;
    logic       a_shift_s;
    logic       b_shift_s;

    // The last FETCH cycle is reached when RD_WAIT cycles have elapsed.
    assign wait_last_s = (wait_cnt_r == 2'(RD_WAIT - 1));
    assign fetching_s  = (state_r == FETCH_A) || (state_r == FETCH_B);

    // An operand still needs shifting while its MSB is clear and its
    // counter has not yet reached 7. A zero operand stops after 7 shifts.
    assign a_shift_s = !MSB_reg_out1 && !carry2;
    assign b_shift_s = !MSB_reg_out2 && !carry3;

    // State register; rst aborts any batch and leaves the datapath untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Counts cycles spent in a FETCH state, covering the registered RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 2'd0;
        end else if (fetching_s && !wait_last_s) begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
        end else begin
            wait_cnt_r <= 2'd0;
        end
    end

    // Next-state and strobe decode (Moore state plus live datapath status).
    always_comb begin
        state_nx_s = state_r;
        ld1        = 1'b0;
        ld2        = 1'b0;
        ld3        = 1'b0;
        ld4        = 1'b0;
        ld5        = 1'b0;
        Inc1       = 1'b0;
        Inc2       = 1'b0;
        Inc3       = 1'b0;
        Inc4       = 1'b0;
        Countrst1  = 1'b0;
        Countrst2  = 1'b0;
        Countrst3  = 1'b0;
        Countrst4  = 1'b0;
        Shle1      = 1'b0;
        Shle2      = 1'b0;
        Shre       = 1'b0;
        We         = 1'b0;
        busy       = (state_r != IDLE);
        done       = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = INIT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            INIT: begin
                Countrst1  = 1'b1;
                Countrst2  = 1'b1;
                Countrst3  = 1'b1;
                Countrst4  = 1'b1;
                state_nx_s = FETCH_A;
            end
            FETCH_A: begin
                if (wait_last_s) begin
                    state_nx_s = LOAD_A;
                end else begin
                    state_nx_s = FETCH_A;
                end
            end
            LOAD_A: begin
                ld1        = 1'b1;
                Inc1       = 1'b1;
                state_nx_s = FETCH_B;
            end
            FETCH_B: begin
                if (wait_last_s) begin
                    state_nx_s = LOAD_B;
                end else begin
                    state_nx_s = FETCH_B;
                end
            end
            LOAD_B: begin
                ld2        = 1'b1;
                Inc1       = 1'b1;
                state_nx_s = NORM;
            end
            NORM: begin
                // Both operands shift in parallel. The cycle where neither
                // shifts is strobe-free and hands over to MULT.
                Shle1 = a_shift_s;
                Inc2  = a_shift_s;
                Shle2 = b_shift_s;
                Inc3  = b_shift_s;
                if (!a_shift_s && !b_shift_s) begin
                    state_nx_s = MULT;
                end else begin
                    state_nx_s = NORM;
                end
            end
            MULT: begin
                // Counters 2/3 become 7 - count, so counting back up to 7
                // yields exactly the normalisation shift count.
                ld4        = 1'b1;
                ld5        = 1'b1;
                ld3        = 1'b1;
                state_nx_s = SHR_A;
            end
            SHR_A: begin
                if (!carry2) begin
                    Shre       = 1'b1;
                    Inc2       = 1'b1;
                    state_nx_s = SHR_A;
                end else begin
                    state_nx_s = SHR_B;
                end
            end
            SHR_B: begin
                if (!carry3) begin
                    Shre       = 1'b1;
                    Inc3       = 1'b1;
                    state_nx_s = SHR_B;
                end else begin
                    state_nx_s = WRITE;
                end
            end
            WRITE: begin
                We         = 1'b1;
                state_nx_s = NEXT;
            end
            NEXT: begin
                // carry4 reflects the address just written. Counter 4
                // wraps 7 -> 0 by itself.
                Inc4      = 1'b1;
                Countrst2 = 1'b1;
                Countrst3 = 1'b1;
                if (carry4) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = FETCH_A;
                end
            end
            DONE: begin
                done       = 1'b1;
                Countrst1  = 1'b1;
                Countrst4  = 1'b1;
                state_nx_s = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_nx_s = IDLE;
            end
        endcase
    end

`ifdef APPROX_MULT_CTRL_PERF_EN
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

    logic [PERF_W-1:0] cycles_r;

    // Busy-cycle counter. The INIT cycle counts itself, so the counter
    // restarts at 1. It saturates at all-ones and holds while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_r <= {PERF_W{1'b0}};
        end else if (state_r == INIT) begin
            cycles_r <= PERF_ONE;
        end else if (busy && (cycles_r != PERF_MAX)) begin
            cycles_r <= cycles_r + PERF_ONE;
        end else begin
            cycles_r <= cycles_r;
        end
    end

    assign cycles = cycles_r;
`endif

endmodule

// File: tb/tb_approx_mult_ctrl.sv
module tb_approx_mult_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic MSB_reg_out1, MSB_reg_out2, carry2, carry3, carry4;
    logic ld1, ld2, ld3, ld4, ld5, Inc1, Inc2, Inc3, Inc4;
    logic Countrst1, Countrst2, Countrst3, Countrst4;
    logic Shle1, Shle2, Shre, We, busy, done;
`ifdef APPROX_MULT_CTRL_PERF_EN
    logic [15:0] cycles;
`endif

    always #5 clk = ~clk;

    approx_mult_ctrl #(.RD_WAIT(1), .PERF_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .MSB_reg_out1(MSB_reg_out1), .MSB_reg_out2(MSB_reg_out2),
        .carry2(carry2), .carry3(carry3), .carry4(carry4),
        .ld1(ld1), .ld2(ld2), .ld3(ld3), .ld4(ld4), .ld5(ld5),
        .Inc1(Inc1), .Inc2(Inc2), .Inc3(Inc3), .Inc4(Inc4),
        .Countrst1(Countrst1), .Countrst2(Countrst2),
        .Countrst3(Countrst3), .Countrst4(Countrst4),
        .Shle1(Shle1), .Shle2(Shle2), .Shre(Shre), .We(We),
        .busy(busy), .done(done)
`ifdef APPROX_MULT_CTRL_PERF_EN
        , .cycles(cycles)
`endif
    );

    // Behavioural datapath model: shift registers and counters driven by the
    // controller's strobes. The input RAM read is modelled as ready in time.
    logic [15:0] ram [0:15];
    logic [15:0] reg_a, reg_b;
    logic [3:0]  cnt1;
    logic [2:0]  cnt2, cnt3, cnt4;
    logic        model_clr;

    assign MSB_reg_out1 = reg_a[15];
    assign MSB_reg_out2 = reg_b[15];
    assign carry2       = (cnt2 == 3'd7);
    assign carry3       = (cnt3 == 3'd7);
    assign carry4       = (cnt4 == 3'd7);

    always @(posedge clk) begin
        if (model_clr) begin
            reg_a <= 16'd0; reg_b <= 16'd0;
            cnt1 <= 4'd0; cnt2 <= 3'd0; cnt3 <= 3'd0; cnt4 <= 3'd0;
        end else begin
            if (ld1) reg_a <= ram[cnt1];
            else if (Shle1) reg_a <= {reg_a[14:0], 1'b0};
            if (ld2) reg_b <= ram[cnt1];
            else if (Shle2) reg_b <= {reg_b[14:0], 1'b0};
            if (Countrst1) cnt1 <= 4'd0;
            else if (Inc1) cnt1 <= cnt1 + 4'd1;
            if (Countrst2) cnt2 <= 3'd0;
            else if (ld5) cnt2 <= 3'd7 - cnt2;
            else if (Inc2) cnt2 <= cnt2 + 3'd1;
            if (Countrst3) cnt3 <= 3'd0;
            else if (ld3) cnt3 <= 3'd7 - cnt3;
            else if (Inc3) cnt3 <= cnt3 + 3'd1;
            if (Countrst4) cnt4 <= 3'd0;
            else if (Inc4) cnt4 <= cnt4 + 3'd1;
        end
    end

    // Strobe monitor, sampled on the falling edge.
    logic mon_clr;
    int   we_total, inc1_total, done_total, init_total, busy_cyc;
    int   p_shle1, p_shle2, p_shre, p_ld4, p_norm;
    bit   in_norm;
    int   rec_shle1 [8], rec_shle2 [8], rec_shre [8], rec_norm [8];
    int   rec_ld4 [8], rec_we [8];

    always @(negedge clk) begin
        if (mon_clr) begin
            we_total <= 0; inc1_total <= 0; done_total <= 0;
            init_total <= 0; busy_cyc <= 0;
            p_shle1 <= 0; p_shle2 <= 0; p_shre <= 0; p_ld4 <= 0; p_norm <= 0;
            in_norm <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rec_shle1[i] <= -1; rec_shle2[i] <= -1; rec_shre[i] <= -1;
                rec_norm[i] <= -1; rec_ld4[i] <= -1; rec_we[i] <= 0;
            end
        end else begin
            if (busy) busy_cyc <= busy_cyc + 1;
            if (Inc1) inc1_total <= inc1_total + 1;
            if (done) done_total <= done_total + 1;
            if (Countrst1 && Countrst2 && Countrst3 && Countrst4)
                init_total <= init_total + 1;
            if (We) begin
                we_total       <= we_total + 1;
                rec_we[cnt4]   <= rec_we[cnt4] + 1;
                rec_shle1[cnt4] <= p_shle1;
                rec_shle2[cnt4] <= p_shle2;
                rec_shre[cnt4]  <= p_shre;
                rec_norm[cnt4]  <= p_norm;
                rec_ld4[cnt4]   <= p_ld4;
            end
            if (Inc4) begin
                p_shle1 <= 0; p_shle2 <= 0; p_shre <= 0; p_ld4 <= 0; p_norm <= 0;
            end else begin
                if (Shle1) p_shle1 <= p_shle1 + 1;
                if (Shle2) p_shle2 <= p_shle2 + 1;
                if (Shre)  p_shre  <= p_shre + 1;
                if (ld4)   p_ld4   <= p_ld4 + 1;
                if (in_norm && !ld2 && !ld4) p_norm <= p_norm + 1;
            end
            if (ld4) in_norm <= 1'b0;
            else if (ld2) in_norm <= 1'b1;
        end
    end

    logic [18:0] all_out;
    assign all_out = {ld1, ld2, ld3, ld4, ld5, Inc1, Inc2, Inc3, Inc4,
                      Countrst1, Countrst2, Countrst3, Countrst4,
                      Shle1, Shle2, Shre, We, busy, done};

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, int'(seen), 1);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; model_clr = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; model_clr = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int shle1;
        int shle2;
        int shre;
        int norm;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{16'h8000, 16'h8000, 0, 0, 0, 1};
        vecs[1] = '{16'h0100, 16'h0001, 7, 7, 14, 8};
        vecs[2] = '{16'h0000, 16'h4000, 7, 1, 8, 8};
        vecs[3] = '{16'h0001, 16'h8000, 7, 0, 7, 8};
        vecs[4] = '{16'h1234, 16'h0FFF, 3, 4, 7, 5};
        vecs[5] = '{16'h4000, 16'h2000, 1, 2, 3, 3};
        vecs[6] = '{16'hFFFF, 16'h00FF, 0, 7, 7, 8};
        vecs[7] = '{16'h0200, 16'h0400, 6, 5, 11, 7};

        rst = 1'b1; start = 1'b0; model_clr = 1'b1; mon_clr = 1'b1;
        for (int i = 0; i < 16; i++) ram[i] = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'(all_out), 0);
        rst = 1'b0; model_clr = 1'b0;
        @(negedge clk);
        check("idle_outputs", int'(all_out), 0);

        // Table-driven batch: one pair per output slot.
        for (int k = 0; k < 8; k++) begin
            ram[2*k]   = vecs[k].a;
            ram[2*k+1] = vecs[k].b;
        end
        mon_clr = 1'b0;
        pulse_start();
        wait_done("table");
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("pair%0d_shle1", k), rec_shle1[k], vecs[k].shle1);
            check($sformatf("pair%0d_shle2", k), rec_shle2[k], vecs[k].shle2);
            check($sformatf("pair%0d_shre", k),  rec_shre[k],  vecs[k].shre);
            check($sformatf("pair%0d_norm", k),  rec_norm[k],  vecs[k].norm);
            check($sformatf("pair%0d_ld4", k),   rec_ld4[k],   1);
            check($sformatf("pair%0d_we", k),    rec_we[k],    1);
        end
        check("table_we_total", we_total, 8);
        check("table_inc1_total", inc1_total, 16);
        check("table_done_total", done_total, 1);
        check("table_idle_after", int'(busy), 0);

        // All-0x8000 batch with start pulses while busy.
        for (int i = 0; i < 16; i++) ram[i] = 16'h8000;
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        pulse_start();
        repeat (5) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done("full");
        repeat (3) @(negedge clk);
        check("full_busy_cycles", busy_cyc, 82);
        check("full_we_total", we_total, 8);
        check("full_inc1_total", inc1_total, 16);
        check("full_done_total", done_total, 1);
        check("full_init_total", init_total, 1);
        check("full_idle_after", int'(all_out), 0);
        for (int k = 0; k < 8; k++)
            check($sformatf("full%0d_shre", k), rec_shre[k], 0);
`ifdef APPROX_MULT_CTRL_PERF_EN
        check("perf_cycles", int'(cycles), 82);
`endif

        // start held high across DONE retriggers one cycle after IDLE.
        start = 1'b1;
        wait_done("hold");
        @(negedge clk);
        check("hold_idle_busy", int'(busy), 0);
        @(negedge clk);
        check("hold_retrig_busy", int'(busy), 1);
        check("hold_retrig_init", int'(Countrst1 & Countrst2 & Countrst3 & Countrst4), 1);
        start = 1'b0;

        // Reset during NORM aborts at once; done never pulses afterwards.
        do_reset();
        for (int i = 0; i < 16; i++) ram[i] = 16'h0100;
        pulse_start();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                if (Shle1) seen = 1'b1;
            end
            check("midnorm_reached", int'(seen), 1);
        end
        rst = 1'b1;
        mon_clr = 1'b1;
        @(negedge clk);
        check("midnorm_rst_outputs", int'(all_out), 0);
        rst = 1'b0;
        mon_clr = 1'b0;
        repeat (20) @(negedge clk);
        check("midnorm_no_done", done_total, 0);
        check("midnorm_no_busy", busy_cyc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
